// File: rtl/tank_bullet_if.sv
// ---------------------------------------------------------------------------
// tank_bullet_if
// Bundles the per-tank bullet signals shared between the tank/obstacle side
// and the bullet generator.
//   fire        : player fire key (level)
//   TankX/TankY : tank centre position
//   tank_dir    : tank facing, 0 up, 1 right, 2 down, 3 left
//   hit         : OR of all hit reports against the live bullet
//   DrawX/DrawY : pixel currently being drawn
//   BullX/BullY : bullet centre, parked at 10'h3FF while no bullet is live
//   bull_active : bullet is live
//   fire_ack    : one-cycle pulse when a bullet spawns
//   is_bullet   : current pixel lies inside the bullet square
// master drives the requests and consumes the bullet state; slave is the
// bullet generator itself.
// ---------------------------------------------------------------------------
interface tank_bullet_if;
  logic       fire;
  logic [9:0] TankX;
  logic [9:0] TankY;
  logic [1:0] tank_dir;
  logic       hit;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] BullX;
  logic [9:0] BullY;
  logic       bull_active;
  logic       fire_ack;
  logic       is_bullet;

  modport master (
    output fire, TankX, TankY, tank_dir, hit, DrawX, DrawY,
    input  BullX, BullY, bull_active, fire_ack, is_bullet
  );

  modport slave (
    input  fire, TankX, TankY, tank_dir, hit, DrawX, DrawY,
    output BullX, BullY, bull_active, fire_ack, is_bullet
  );
endinterface

// File: rtl/tank_bullet.sv
// ---------------------------------------------------------------------------
// tank_bullet
// Per-tank projectile generator. A rising edge of fire arms a shot while the
// generator is idle; the next frame tick spawns the bullet TANK_SIZE+1 pixels
// in front of the tank (if that point is on the playfield). The bullet then
// moves BULL_SPEED pixels per frame tick in the direction latched at spawn,
// until a hit report or until the next step would leave the playfield. After
// retirement the generator waits COOLDOWN_FRAMES ticks before re-arming.
// Ports:
//   Clk       : system clock
//   Reset_h   : synchronous active-high reset
//   frame_clk : frame-rate signal, rising edge = frame tick
//   bus       : tank_bullet_if slave (fire/tank/hit/draw in, bullet state out)
// ---------------------------------------------------------------------------
module tank_bullet #(
  parameter logic [9:0] BULL_SPEED      = 10'd4,
  parameter logic [9:0] TANK_SIZE       = 10'd8,
  parameter logic [9:0] BULL_HALF       = 10'd1,
  parameter logic [9:0] X_MIN           = 10'd0,
  parameter logic [9:0] X_MAX           = 10'd639,
  parameter logic [9:0] Y_MIN           = 10'd0,
  parameter logic [9:0] Y_MAX           = 10'd479,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd15,
  parameter logic [9:0] PARK            = 10'h3FF
) (
  input  logic         Clk,
  input  logic         Reset_h,
  input  logic         frame_clk,
  tank_bullet_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_e;

  // All position arithmetic is done one bit wider so sums and differences
  // near the 10-bit limits can be compared without wrapping.
  localparam logic [10:0] SPEED_W = {1'b0, BULL_SPEED};
  localparam logic [10:0] HALF_W  = {1'b0, BULL_HALF};
  localparam logic [10:0] OFF_W   = {1'b0, TANK_SIZE} + 11'd1;
  localparam logic [10:0] XMIN_W  = {1'b0, X_MIN};
  localparam logic [10:0] XMAX_W  = {1'b0, X_MAX};
  localparam logic [10:0] YMIN_W  = {1'b0, Y_MIN};
  localparam logic [10:0] YMAX_W  = {1'b0, Y_MAX};

  state_e      state_q, state_d;
  logic [9:0]  bull_x_q, bull_x_d;
  logic [9:0]  bull_y_q, bull_y_d;
  logic [1:0]  dir_q, dir_d;
  logic        bull_active_q, bull_active_d;
  logic        fire_ack_q, fire_ack_d;
  logic [7:0]  cool_q, cool_d;
  logic        fire_pend_q, fire_pend_d;
  logic        frame_clk_dly_q, frame_clk_dly_d;
  logic        fire_dly_q, fire_dly_d;

  logic        tick_s;
  logic        fire_rise_s;
  logic [10:0] tank_x_s, tank_y_s;
  logic [10:0] spawn_x_s, spawn_y_s;
  logic        spawn_under_s;
  logic        spawn_ok_s;
  logic [10:0] bull_xw_s, bull_yw_s;
  logic [10:0] next_x_s, next_y_s;
  logic        leave_s;

  assign tick_s      = frame_clk & ~frame_clk_dly_q;
  assign fire_rise_s = bus.fire & ~fire_dly_q;
  assign bull_xw_s   = {1'b0, bull_x_q};
  assign bull_yw_s   = {1'b0, bull_y_q};

  // Spawn point in front of the tank and whether it lands on the playfield.
  always_comb begin
    tank_x_s      = {1'b0, bus.TankX};
    tank_y_s      = {1'b0, bus.TankY};
    spawn_x_s     = tank_x_s;
    spawn_y_s     = tank_y_s;
    spawn_under_s = 1'b0;
    case (bus.tank_dir)
      2'd0: begin
        spawn_y_s     = tank_y_s - OFF_W;
        spawn_under_s = (tank_y_s < (YMIN_W + OFF_W));
      end
      2'd1: begin
        spawn_x_s = tank_x_s + OFF_W;
      end
      2'd2: begin
        spawn_y_s = tank_y_s + OFF_W;
      end
      2'd3: begin
        spawn_x_s     = tank_x_s - OFF_W;
        spawn_under_s = (tank_x_s < (XMIN_W + OFF_W));
      end
      default: begin
        spawn_under_s = 1'b1;
      end
    endcase
    // "+1 > MIN" is the lower-bound test written so it stays meaningful
    // when a bound parameter is zero; wrapped values are already refused
    // by spawn_under_s.
    spawn_ok_s = ~spawn_under_s
               & ((spawn_x_s + 11'd1) > XMIN_W) & (spawn_x_s <= XMAX_W)
               & ((spawn_y_s + 11'd1) > YMIN_W) & (spawn_y_s <= YMAX_W);
  end

  // Next bullet position along the latched direction; leave_s flags a step
  // that would cross the playfield edge.
  always_comb begin
    next_x_s = bull_xw_s;
    next_y_s = bull_yw_s;
    leave_s  = 1'b0;
    case (dir_q)
      2'd0: begin
        leave_s  = (bull_yw_s < (YMIN_W + SPEED_W));
        next_y_s = bull_yw_s - SPEED_W;
      end
      2'd1: begin
        leave_s  = ((bull_xw_s + SPEED_W) > XMAX_W);
        next_x_s = bull_xw_s + SPEED_W;
      end
      2'd2: begin
        leave_s  = ((bull_yw_s + SPEED_W) > YMAX_W);
        next_y_s = bull_yw_s + SPEED_W;
      end
      2'd3: begin
        leave_s  = (bull_xw_s < (XMIN_W + SPEED_W));
        next_x_s = bull_xw_s - SPEED_W;
      end
      default: begin
        leave_s = 1'b1;
      end
    endcase
  end

  // Next-state logic for the IDLE / FLY / COOL controller and its outputs.
  always_comb begin
    state_d         = state_q;
    bull_x_d        = bull_x_q;
    bull_y_d        = bull_y_q;
    dir_d           = dir_q;
    bull_active_d   = bull_active_q;
    fire_ack_d      = 1'b0;
    cool_d          = cool_q;
    fire_pend_d     = fire_pend_q;
    frame_clk_dly_d = frame_clk;
    fire_dly_d      = bus.fire;
    case (state_q)
      IDLE: begin
        if (tick_s && fire_pend_q) begin
          // The armed shot is consumed whether or not it can spawn.
          fire_pend_d = 1'b0;
          dir_d       = bus.tank_dir;
          if (spawn_ok_s) begin
            state_d       = FLY;
            bull_x_d      = spawn_x_s[9:0];
            bull_y_d      = spawn_y_s[9:0];
            bull_active_d = 1'b1;
            fire_ack_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (fire_rise_s) begin
          fire_pend_d = 1'b1;
        end else begin
          fire_pend_d = fire_pend_q;
        end
      end
      FLY: begin
        // A hit report outranks a coincident frame tick.
        if (bus.hit || (tick_s && leave_s)) begin
          state_d       = COOL;
          bull_x_d      = PARK;
          bull_y_d      = PARK;
          bull_active_d = 1'b0;
          cool_d        = COOLDOWN_FRAMES;
        end else if (tick_s) begin
          bull_x_d = next_x_s[9:0];
          bull_y_d = next_y_s[9:0];
        end else begin
          state_d = FLY;
        end
      end
      COOL: begin
        if (cool_q == 8'd0) begin
          state_d = IDLE;
        end else if (tick_s) begin
          cool_d = cool_q - 8'd1;
        end else begin
          state_d = COOL;
        end
      end
      default: begin
        state_d       = IDLE;
        bull_x_d      = PARK;
        bull_y_d      = PARK;
        bull_active_d = 1'b0;
        cool_d        = 8'd0;
        fire_pend_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q         <= IDLE;
      bull_x_q        <= PARK;
      bull_y_q        <= PARK;
      dir_q           <= 2'd0;
      bull_active_q   <= 1'b0;
      fire_ack_q      <= 1'b0;
      cool_q          <= 8'd0;
      fire_pend_q     <= 1'b0;
      frame_clk_dly_q <= 1'b0;
      fire_dly_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      bull_x_q        <= bull_x_d;
      bull_y_q        <= bull_y_d;
      dir_q           <= dir_d;
      bull_active_q   <= bull_active_d;
      fire_ack_q      <= fire_ack_d;
      cool_q          <= cool_d;
      fire_pend_q     <= fire_pend_d;
      frame_clk_dly_q <= frame_clk_dly_d;
      fire_dly_q      <= fire_dly_d;
    end
  end

  assign bus.BullX       = bull_x_q;
  assign bus.BullY       = bull_y_q;
  assign bus.bull_active = bull_active_q;
  assign bus.fire_ack    = fire_ack_q;

  // Pixel-in-square test, widened so DrawX+BULL_HALF cannot wrap.
  assign bus.is_bullet = bull_active_q
                       & (({1'b0, bus.DrawX} + HALF_W) >= bull_xw_s)
                       & ({1'b0, bus.DrawX} <= (bull_xw_s + HALF_W))
                       & (({1'b0, bus.DrawY} + HALF_W) >= bull_yw_s)
                       & ({1'b0, bus.DrawY} <= (bull_yw_s + HALF_W));

endmodule

// File: tb/tb_tank_bullet.sv
// ---------------------------------------------------------------------------
// tb_tank_bullet
// Table of hand-derived cycle vectors for reset, spawn, flight and hit; hand
// sequences for cooldown, exits, refused spawns and the draw window; then a
// randomized run compared against a pixel-level behavioural model.
// ---------------------------------------------------------------------------
module tb_tank_bullet;
  localparam int PARKV = 1023;
  localparam int COOLN = 15;

  logic Clk = 1'b0;
  logic Reset_h;
  logic frame_clk;

  tank_bullet_if bus_i ();

  tank_bullet dut (
    .Clk      (Clk),
    .Reset_h  (Reset_h),
    .frame_clk(frame_clk),
    .bus      (bus_i)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a bullet is either live at (m_x,m_y) with a unit
  // velocity, cooling with m_cool frames left, or idle (m_cool < 0).
  int m_live = 0, m_x = 0, m_y = 0, m_vx = 0, m_vy = 0;
  int m_cool = -1, m_pend = 0, m_ack = 0, m_frame_prev = 0, m_fire_prev = 0;

  typedef struct packed {
    bit       rst;
    bit       fr;
    bit       fi;
    bit       hit;
    bit [1:0] dir;
    int       drx;
    int       dry;
    int       ex;
    int       ey;
    bit       ea;
    bit       ek;
    bit       eb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int vx_of(input int d);
    return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
  endfunction

  function automatic int vy_of(input int d);
    return (d == 0) ? -1 : ((d == 2) ? 1 : 0);
  endfunction

  function automatic bit on_field(input int x, input int y);
    return (x >= 0) && (x <= 639) && (y >= 0) && (y <= 479);
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    int tick, rise, sx, sy, nx, ny, d;
    tick  = (frame_clk && !m_frame_prev) ? 1 : 0;
    rise  = (bus_i.fire && !m_fire_prev) ? 1 : 0;
    m_ack = 0;
    if (Reset_h) begin
      m_live = 0; m_cool = -1; m_pend = 0; m_frame_prev = 0; m_fire_prev = 0;
      return;
    end
    if (m_live != 0) begin
      if (bus_i.hit) begin
        m_live = 0; m_cool = COOLN;
      end else if (tick != 0) begin
        nx = m_x + 4 * m_vx;
        ny = m_y + 4 * m_vy;
        if (on_field(nx, ny)) begin
          m_x = nx; m_y = ny;
        end else begin
          m_live = 0; m_cool = COOLN;
        end
      end
    end else if (m_cool >= 0) begin
      if (m_cool == 0) m_cool = -1;
      else if (tick != 0) m_cool--;
    end else begin
      if ((tick != 0) && (m_pend != 0)) begin
        m_pend = 0;
        d  = int'(bus_i.tank_dir);
        sx = int'(bus_i.TankX) + 9 * vx_of(d);
        sy = int'(bus_i.TankY) + 9 * vy_of(d);
        if (on_field(sx, sy)) begin
          m_live = 1; m_x = sx; m_y = sy; m_vx = vx_of(d); m_vy = vy_of(d); m_ack = 1;
        end
      end else if (rise != 0) begin
        m_pend = 1;
      end
    end
    m_frame_prev = frame_clk ? 1 : 0;
    m_fire_prev  = bus_i.fire ? 1 : 0;
  endtask

  function automatic int m_isb();
    int ddx, ddy;
    ddx = int'(bus_i.DrawX) - m_x;
    ddy = int'(bus_i.DrawY) - m_y;
    return ((m_live != 0) && ddx >= -1 && ddx <= 1 && ddy >= -1 && ddy <= 1) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input bit rst, input bit fr, input bit fi, input bit h);
    Reset_h = rst; frame_clk = fr; bus_i.fire = fi; bus_i.hit = h;
    step();
  endtask

  task automatic expect_out(input string name, input int ex, input int ey, input int ea, input int ek);
    chk({name, "_x"}, int'(bus_i.BullX), ex);
    chk({name, "_y"}, int'(bus_i.BullY), ey);
    chk({name, "_active"}, int'(bus_i.bull_active), ea);
    chk({name, "_ack"}, int'(bus_i.fire_ack), ek);
  endtask

  task automatic compare_model();
    chk("rnd_x", int'(bus_i.BullX), (m_live != 0) ? m_x : PARKV);
    chk("rnd_y", int'(bus_i.BullY), (m_live != 0) ? m_y : PARKV);
    chk("rnd_active", int'(bus_i.bull_active), m_live);
    chk("rnd_ack", int'(bus_i.fire_ack), m_ack);
    chk("rnd_isb", int'(bus_i.is_bullet), m_isb());
  endtask

  // Fifteen frame ticks of cooldown plus the cycle that returns to idle.
  task automatic wait_cool(input string name);
    for (int k = 0; k < COOLN; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_out(name, PARKV, PARKV, 0, 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic addv(input bit rst, input bit fr, input bit fi, input bit hit, input bit [1:0] dir,
                      input int drx, input int dry, input int ex, input int ey,
                      input bit ea, input bit ek, input bit eb);
    vec_t v;
    v.rst = rst; v.fr = fr; v.fi = fi; v.hit = hit; v.dir = dir;
    v.drx = drx; v.dry = dry; v.ex = ex; v.ey = ey; v.ea = ea; v.ek = ek; v.eb = eb;
    tbl.push_back(v);
  endtask

  initial begin
    int ones, r;
    Reset_h = 1'b1; frame_clk = 1'b0;
    bus_i.fire = 1'b0; bus_i.hit = 1'b0; bus_i.tank_dir = 2'd1;
    bus_i.TankX = 10'd100; bus_i.TankY = 10'd200;
    bus_i.DrawX = 10'd0; bus_i.DrawY = 10'd0;

    //      rst fr fi hit dir drx  dry  ex     ey     ea ek eb
    addv(1, 0, 0, 0, 1,   0,   0, PARKV, PARKV, 0, 0, 0);
    addv(1, 0, 0, 0, 1,   0,   0, PARKV, PARKV, 0, 0, 0);
    addv(0, 0, 0, 0, 1,   0,   0, PARKV, PARKV, 0, 0, 0);
    addv(0, 0, 1, 0, 1,   0,   0, PARKV, PARKV, 0, 0, 0);
    addv(0, 0, 0, 0, 1,   0,   0, PARKV, PARKV, 0, 0, 0);
    addv(0, 1, 0, 0, 1, 109, 200, 109,   200,   1, 1, 1);
    addv(0, 1, 0, 0, 1, 111, 200, 109,   200,   1, 0, 0);
    addv(0, 0, 0, 0, 1, 110, 201, 109,   200,   1, 0, 1);
    addv(0, 1, 0, 0, 1,   0,   0, 113,   200,   1, 0, 0);
    addv(0, 0, 0, 0, 1,   0,   0, 113,   200,   1, 0, 0);
    addv(0, 1, 0, 0, 0,   0,   0, 117,   200,   1, 0, 0);
    addv(0, 0, 0, 0, 1, 116, 199, 117,   200,   1, 0, 1);
    addv(0, 1, 0, 1, 1, 117, 200, PARKV, PARKV, 0, 0, 0);

    foreach (tbl[i]) begin
      bus_i.tank_dir = tbl[i].dir;
      bus_i.DrawX = 10'(tbl[i].drx);
      bus_i.DrawY = 10'(tbl[i].dry);
      cyc(tbl[i].rst, tbl[i].fr, tbl[i].fi, tbl[i].hit);
      chk($sformatf("vec%0d_x", i), int'(bus_i.BullX), tbl[i].ex);
      chk($sformatf("vec%0d_y", i), int'(bus_i.BullY), tbl[i].ey);
      chk($sformatf("vec%0d_active", i), int'(bus_i.bull_active), int'(tbl[i].ea));
      chk($sformatf("vec%0d_ack", i), int'(bus_i.fire_ack), int'(tbl[i].ek));
      chk($sformatf("vec%0d_isb", i), int'(bus_i.is_bullet), int'(tbl[i].eb));
    end

    // Cooldown: fire presses during the 15 cooling ticks are ignored.
    for (int k = 0; k < COOLN; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("cool_fire", PARKV, PARKV, 0, 0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("cool_tick", PARKV, PARKV, 0, 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("respawn", 109, 200, 1, 1);

    // Reset while flying parks at once with no ack.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("midreset", PARKV, PARKV, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Upward shot near the top edge: 11, 7, 3, then retire.
    bus_i.tank_dir = 2'd0; bus_i.TankX = 10'd50; bus_i.TankY = 10'd20;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("up_spawn", 50, 11, 1, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("up_7", 50, 7, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("up_3", 50, 3, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("up_exit", PARKV, PARKV, 0, 0);
    wait_cool("up_cool");

    // Left shot too close to the left edge is refused; a later one spawns.
    bus_i.tank_dir = 2'd3; bus_i.TankX = 10'd5; bus_i.TankY = 10'd150;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("left_refuse", PARKV, PARKV, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    bus_i.TankX = 10'd300;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("left_spawn", 291, 150, 1, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("left_hit", PARKV, PARKV, 0, 0);
    wait_cool("left_cool");

    // Bullet at (200,150): sweep a 7x7 window around it.
    bus_i.tank_dir = 2'd1; bus_i.TankX = 10'd191; bus_i.TankY = 10'd150;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("sweep_spawn", 200, 150, 1, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    ones = 0;
    for (int ox = -3; ox <= 3; ox++) begin
      for (int oy = -3; oy <= 3; oy++) begin
        bus_i.DrawX = 10'(200 + ox);
        bus_i.DrawY = 10'(150 + oy);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk($sformatf("sweep_%0d_%0d", ox, oy), int'(bus_i.is_bullet),
            (ox >= -1 && ox <= 1 && oy >= -1 && oy <= 1) ? 1 : 0);
        ones += int'(bus_i.is_bullet);
      end
    end
    chk("sweep_count", ones, 9);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("sweep_hit", PARKV, PARKV, 0, 0);

    // Randomized run against the model.
    for (int n = 0; n < 5000; n++) begin
      Reset_h = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
      if ($urandom_range(0, 5) == 0) bus_i.fire = ~bus_i.fire;
      bus_i.hit = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) bus_i.tank_dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 7) begin
          bus_i.TankX = 10'($urandom_range(0, 639));
          bus_i.TankY = 10'($urandom_range(0, 479));
        end else if (r == 7) begin
          bus_i.TankX = 10'($urandom_range(0, 12));
          bus_i.TankY = 10'($urandom_range(0, 12));
        end else if (r == 8) begin
          bus_i.TankX = 10'($urandom_range(627, 639));
          bus_i.TankY = 10'($urandom_range(467, 479));
        end else begin
          bus_i.TankX = 10'($urandom_range(0, 1023));
          bus_i.TankY = 10'($urandom_range(0, 1023));
        end
      end
      if (m_live != 0) begin
        bus_i.DrawX = 10'(m_x + int'($urandom_range(0, 4)) - 2);
        bus_i.DrawY = 10'(m_y + int'($urandom_range(0, 4)) - 2);
      end else begin
        bus_i.DrawX = 10'($urandom_range(0, 1023));
        bus_i.DrawY = 10'($urandom_range(0, 1023));
      end
      step();
      compare_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tank_bullet.md
Name: tank_bullet

Overview:
Per-tank projectile generator. It is the launching end of the bullet/hit interface that obstacle and tank blocks consume. It spawns a bullet in front of its tank on a fire request, advances it once per frame, and drives BullX/BullY. It retires the bullet on a hit report or on leaving the playfield, then enforces a reload cooldown. It also produces the per-pixel bullet draw flag for the colour mapper.

Parameters:
BULL_SPEED, 10'd4, pixels moved per frame tick
TANK_SIZE, 10'd8, half-width of tank sprite; spawn offset = TANK_SIZE+1 from tank centre
BULL_HALF, 10'd1, half-size of drawn bullet square
X_MIN, 10'd0, left playfield bound (inclusive)
X_MAX, 10'd639, right playfield bound (inclusive)
Y_MIN, 10'd0, top playfield bound (inclusive)
Y_MAX, 10'd479, bottom playfield bound (inclusive)
COOLDOWN_FRAMES, 8'd15, frame ticks spent in COOL before the next shot is accepted
PARK, 10'h3FF, BullX/BullY value while no bullet is live

Ports:
Clk  in  1  system clock
Reset_h  in  1  synchronous active-high reset
frame_clk  in  1  vertical-sync-rate signal; rising edge = frame tick
fire  in  1  player fire key, level
TankX  in  10  tank centre X
TankY  in  10  tank centre Y
tank_dir  in  2  tank facing: 0 up (Y-), 1 right (X+), 2 down (Y+), 3 left (X-)
hit  in  1  OR of all hit reports for this bullet (obstacle hitobjN, opposing tank)
BullX  out  10  bullet centre X, PARK when inactive
BullY  out  10  bullet centre Y, PARK when inactive
bull_active  out  1  bullet live (state FLY)
fire_ack  out  1  one-cycle pulse on spawn
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
is_bullet  out  1  current pixel lies inside the bullet square

Behaviour:
- One clock, Clk. Reset is synchronous and active-high on Reset_h.
- Reset values: state IDLE, BullX=BullY=PARK, bull_active=0, fire_ack=0, cooldown count=0, fire_pend=0, frame_clk_d=0, fire_d=0.
- tick = frame_clk & ~frame_clk_d, with frame_clk_d registered every cycle.
- fire_rise = fire & ~fire_d. A fire_rise in IDLE sets fire_pend. A fire_rise in FLY or COOL is ignored; there is no queueing. Holding fire does not auto-repeat.
- State IDLE: on tick with fire_pend, compute the spawn point from TankX/TankY sampled that cycle, offset by TANK_SIZE+1 along tank_dir, and latch the direction.
  - If the spawn point is inside [X_MIN,X_MAX]x[Y_MIN,Y_MAX]: load BullX/BullY, pulse fire_ack, go to FLY.
  - Otherwise: stay in IDLE, no ack.
  - fire_pend clears on that tick in both cases.
  - Underflow check for up/left spawn: when TankY < Y_MIN+TANK_SIZE+1 (or the X equivalent), the shot is refused.
- State FLY: bull_active=1.
  - If hit=1 in any cycle: park, go to COOL, load cooldown=COOLDOWN_FRAMES.
  - Else on tick, check bounds before moving:
    - up: BullY < Y_MIN+BULL_SPEED
    - left: BullX < X_MIN+BULL_SPEED
    - down: BullY+BULL_SPEED > Y_MAX
    - right: BullX+BULL_SPEED > X_MAX
  - If the bound check is true: park, go to COOL.
  - Else: move BULL_SPEED in the latched direction.
  - hit and tick in the same cycle: hit wins; no move.
  - Changes to tank_dir during flight have no effect.
- State COOL: on each tick, decrement cooldown. When the count is 0, go to IDLE on the next cycle. COOLDOWN_FRAMES=0 gives one cycle in COOL.
- Position updates are registered: BullX/BullY change the cycle after tick/hit.
- is_bullet (combinational) = bull_active & (DrawX+BULL_HALF >= BullX) & (DrawX <= BullX+BULL_HALF) & (DrawY+BULL_HALF >= BullY) & (DrawY <= BullY+BULL_HALF).
- Reset mid-flight: the bullet parks immediately on the next edge and no ack is issued.

Test Plan:
- Reset held 2 cycles, then released -> BullX=BullY=1023, bull_active=0, is_bullet=0.
- TankX=100, TankY=200, tank_dir=1, fire pulse, then tick -> fire_ack for 1 cycle, BullX=109, BullY=200. Next tick -> BullX=113. Tick after that -> BullX=117.
- Bullet in flight at (117,200), hit=1 for 1 cycle coincident with tick -> park at 1023/1023, no move. Fire pulse during the following 15 ticks is ignored. Fire after the 15th tick -> new spawn.
- tank_dir=0, TankY=20, TankX=50, fire + tick -> BullY=11. Ticks -> 7, then 3. Next tick -> parked, bull_active=0.
- tank_dir=3, TankX=5, fire + tick -> no fire_ack, stays IDLE. A later fire with TankX=300 -> spawn at BullX=291.
- Bullet at (200,150), BULL_HALF=1: DrawX/DrawY sweep -> is_bullet=1 only for X 199..201 and Y 149..151 (9 pixels).
